// File: rtl/apb_seq_controller.sv
// AHB-to-APB sequencing controller.
// Accepts AHB address phases aimed at the APB window and turns each into an
// APB setup/access pair. Writes take an extra wait cycle so the AHB data
// phase can be captured. All APB and ready outputs are registered and are
// decoded from the next state, so each value holds for the whole state.
module apb_seq_controller (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        valid,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADYin,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  TEMP_SEL,
    output logic [2:0]  PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        HREADYout
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_READ, ST_RENABLE, ST_WWAIT, ST_WRITE, ST_WENABLE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;

    logic [2:0]  psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        hready_q, hready_d;

    logic        accept;
    logic        can_accept;

    // NONSEQ or SEQ only; BUSY and IDLE never start a transfer.
    assign accept     = valid && HREADYin && ((HTRANS == 2'b10) || (HTRANS == 2'b11));
    // A new address phase is only taken while the master sees HREADYout=1.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_RENABLE) ||
                        (state_q == ST_WENABLE);

    // State and output registers; reset aborts any transfer immediately.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            wdata_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            hready_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            hready_q  <= hready_d;
        end
    end

    // Next-state logic plus capture of address/select/write data.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (accept) begin
                    state_d = HWRITE ? ST_WWAIT : ST_READ;
                    addr_d  = HADDR;
                    sel_d   = TEMP_SEL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ:  state_d = ST_RENABLE;
            ST_WWAIT: begin
                state_d = ST_WRITE;
                wdata_d = HWDATA;
            end
            ST_WRITE: state_d = ST_WENABLE;
            default:  state_d = ST_IDLE;
        endcase
        if (!can_accept) begin
            addr_d = addr_q;
            sel_d  = sel_q;
        end
    end

    // Output decode from the next state; the capture values used here are
    // the ones being loaded on the same edge.
    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        hready_d  = hready_q;
        case (state_d)
            ST_IDLE: begin
                psel_d = '0; penable_d = 1'b0; hready_d = 1'b1;
            end
            ST_READ, ST_RENABLE: begin
                psel_d    = sel_d;
                paddr_d   = addr_d;
                pwrite_d  = 1'b0;
                penable_d = (state_d == ST_RENABLE);
                hready_d  = (state_d == ST_RENABLE);
            end
            ST_WWAIT: begin
                psel_d = '0; penable_d = 1'b0; hready_d = 1'b0;
            end
            ST_WRITE, ST_WENABLE: begin
                psel_d    = sel_d;
                paddr_d   = addr_d;
                pwdata_d  = wdata_d;
                pwrite_d  = 1'b1;
                penable_d = (state_d == ST_WENABLE);
                hready_d  = (state_d == ST_WENABLE);
            end
            default: begin
                psel_d = '0; penable_d = 1'b0; hready_d = 1'b1;
            end
        endcase
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign HREADYout = hready_q;

endmodule

// File: tb/tb_apb_seq_controller.sv
// Bench for apb_seq_controller: directed scenarios then random traffic,
// checked cycle by cycle against a transaction-queue reference model.
module tb_apb_seq_controller;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        valid;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADYin;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [2:0]  TEMP_SEL;
    logic [2:0]  PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        HREADYout;

    int errors = 0;
    int checks = 0;

    apb_seq_controller dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .valid(valid), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADYin(HREADYin), .HADDR(HADDR), .HWDATA(HWDATA),
        .TEMP_SEL(TEMP_SEL), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .HREADYout(HREADYout)
    );

    always #5 HCLK = ~HCLK;

    // Expected bus outputs for the current cycle.
    typedef struct {
        logic [2:0]  psel;
        logic        pen;
        logic        pw;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        hr;
    } out_t;

    // One pending APB cycle of an accepted transfer.
    localparam logic [2:0] K_WWAIT = 3'd0, K_RSET = 3'd1, K_WSET = 3'd2, K_EN = 3'd3;
    typedef struct packed {
        logic [2:0]  kind;
        logic [2:0]  sel;
        logic [31:0] addr;
    } rec_t;

    out_t cur;
    rec_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur = '{psel: 3'b000, pen: 1'b0, pw: 1'b0, paddr: 32'h0, pwdata: 32'h0, hr: 1'b1};
        q.delete();
    endtask

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_step();
        out_t n;
        rec_t r;
        if (cur.hr && valid && HTRANS[1] && HREADYin) begin
            if (HWRITE) begin
                q.push_back('{kind: K_WWAIT, sel: TEMP_SEL, addr: HADDR});
                q.push_back('{kind: K_WSET,  sel: TEMP_SEL, addr: HADDR});
                q.push_back('{kind: K_EN,    sel: TEMP_SEL, addr: HADDR});
            end else begin
                q.push_back('{kind: K_RSET,  sel: TEMP_SEL, addr: HADDR});
                q.push_back('{kind: K_EN,    sel: TEMP_SEL, addr: HADDR});
            end
        end
        n = cur;
        if (q.size() == 0) begin
            n.psel = 3'b000; n.pen = 1'b0; n.hr = 1'b1;
        end else begin
            r = q.pop_front();
            case (r.kind)
                K_WWAIT: begin n.psel = 3'b000; n.pen = 1'b0; n.hr = 1'b0; end
                K_RSET: begin
                    n.psel = r.sel; n.paddr = r.addr; n.pw = 1'b0; n.pen = 1'b0; n.hr = 1'b0;
                end
                K_WSET: begin
                    n.psel = r.sel; n.paddr = r.addr; n.pw = 1'b1; n.pwdata = HWDATA;
                    n.pen = 1'b0; n.hr = 1'b0;
                end
                default: begin n.pen = 1'b1; n.hr = 1'b1; end
            endcase
        end
        cur = n;
    endtask

    task automatic cmp_all();
        chk("psel",    32'(PSEL),      32'(cur.psel));
        chk("penable", 32'(PENABLE),   32'(cur.pen));
        chk("pwrite",  32'(PWRITE),    32'(cur.pw));
        chk("paddr",   PADDR,          cur.paddr);
        chk("pwdata",  PWDATA,         cur.pwdata);
        chk("hready",  32'(HREADYout), 32'(cur.hr));
    endtask

    task automatic drive(input logic v, input logic [1:0] tr, input logic wr, input logic rdy,
                         input logic [31:0] a, input logic [31:0] wd, input logic [2:0] sel);
        valid = v; HTRANS = tr; HWRITE = wr; HREADYin = rdy;
        HADDR = a; HWDATA = wd; TEMP_SEL = sel;
    endtask

    task automatic drive_idle();
        drive(1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 3'b000);
    endtask

    // Inputs are set at the falling edge; the model advances at the rising
    // edge; outputs are compared at the next falling edge.
    task automatic cycle();
        @(posedge HCLK);
        model_step();
        @(negedge HCLK);
        cmp_all();
    endtask

    // Asynchronous reset asserted between edges, held across one rising edge.
    task automatic do_reset();
        HRESETn = 1'b0;
        #1;
        model_reset();
        cmp_all();
        chk("rst_psel", 32'(PSEL), 32'h0);
        chk("rst_hready", 32'(HREADYout), 32'h1);
        @(negedge HCLK);
        cmp_all();
        HRESETn = 1'b1;
    endtask

    initial begin
        HRESETn = 1'b0;
        drive_idle();
        @(negedge HCLK);
        do_reset();

        // Read to 0x4000_1004, select 010.
        drive(1'b1, 2'b10, 1'b0, 1'b1, 32'h4000_1004, 32'h0, 3'b010);
        cycle();
        chk("rd_setup_psel", 32'(PSEL), 32'h2);
        chk("rd_setup_paddr", PADDR, 32'h4000_1004);
        chk("rd_setup_pen", 32'(PENABLE), 32'h0);
        chk("rd_setup_hr", 32'(HREADYout), 32'h0);
        drive_idle();
        cycle();
        chk("rd_en_pen", 32'(PENABLE), 32'h1);
        chk("rd_en_hr", 32'(HREADYout), 32'h1);
        cycle();
        chk("rd_idle_psel", 32'(PSEL), 32'h0);

        // Write 0xDEAD_BEEF to 0x4000_2008, select 100, then a back-to-back read.
        drive(1'b1, 2'b10, 1'b1, 1'b1, 32'h4000_2008, 32'h0, 3'b100);
        cycle();
        chk("wr_wait_hr", 32'(HREADYout), 32'h0);
        chk("wr_wait_psel", 32'(PSEL), 32'h0);
        drive(1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF, 3'b000);
        cycle();
        chk("wr_setup_psel", 32'(PSEL), 32'h4);
        chk("wr_setup_pwrite", 32'(PWRITE), 32'h1);
        chk("wr_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
        drive_idle();
        cycle();
        chk("wr_en_pen", 32'(PENABLE), 32'h1);
        chk("wr_en_hr", 32'(HREADYout), 32'h1);
        drive(1'b1, 2'b11, 1'b0, 1'b1, 32'h4000_3000, 32'h0, 3'b001);
        cycle();
        chk("b2b_pen", 32'(PENABLE), 32'h0);
        chk("b2b_paddr", PADDR, 32'h4000_3000);
        chk("b2b_psel", 32'(PSEL), 32'h1);
        drive_idle();
        cycle();
        cycle();

        // Rejected phases: BUSY, valid=0, HREADYin=0, five cycles each.
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 5; c++) begin
                case (k)
                    0:       drive(1'b1, 2'b01, 1'b1, 1'b1, 32'h4000_0010, 32'h1, 3'b001);
                    1:       drive(1'b0, 2'b10, 1'b0, 1'b1, 32'h4000_0020, 32'h2, 3'b010);
                    default: drive(1'b1, 2'b10, 1'b1, 1'b0, 32'h4000_0030, 32'h3, 3'b100);
                endcase
                cycle();
                chk("rej_psel", 32'(PSEL), 32'h0);
                chk("rej_hr", 32'(HREADYout), 32'h1);
            end
        end

        // Reset while in the write setup cycle, then a clean read.
        drive(1'b1, 2'b10, 1'b1, 1'b1, 32'h4000_4444, 32'h0, 3'b010);
        cycle();
        drive(1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 3'b000);
        cycle();
        chk("pre_rst_pwrite", 32'(PWRITE), 32'h1);
        drive_idle();
        do_reset();
        chk("post_rst_pwdata", PWDATA, 32'h0);
        drive(1'b1, 2'b10, 1'b0, 1'b1, 32'h4000_5550, 32'h0, 3'b001);
        cycle();
        chk("post_rst_paddr", PADDR, 32'h4000_5550);
        drive_idle();
        cycle();
        cycle();

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) begin
                drive_idle();
                do_reset();
            end
            drive($urandom_range(3) != 0, 2'($urandom_range(3)), 1'($urandom_range(1)),
                  $urandom_range(4) != 0, {16'h4000, 16'($urandom)}, $urandom,
                  3'b001 << $urandom_range(2));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_seq_controller.md
APB_SEQ_CONTROLLER -- requirements
Module: apb_seq_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named HCLK and HRESETn.
REQ-002 HCLK  in  1  system clock; all state and output registers update on its rising edge.
REQ-003 HRESETn  in  1  asynchronous active-low reset.
REQ-004 valid  in  1  the current HADDR decodes to the APB window (0x4000_0000..0x4000_FFFF).
REQ-005 HTRANS  in  2  AHB transfer type; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-006 HWRITE  in  1  AHB direction of the address phase; 1 = write.
REQ-007 HREADYin  in  1  AHB bus ready; the address phase is sampled only when this is 1.
REQ-008 HADDR  in  32  AHB address of the current address phase.
REQ-009 HWDATA  in  32  AHB write data of the current data phase.
REQ-010 TEMP_SEL  in  3  one-hot peripheral select decoded from HADDR.
REQ-011 PSEL  out  3  registered one-hot APB select.
REQ-012 PENABLE  out  1  registered APB enable (access phase).
REQ-013 PWRITE  out  1  registered APB direction.
REQ-014 PADDR  out  32  registered APB address.
REQ-015 PWDATA  out  32  registered APB write data.
REQ-016 HREADYout  out  1  registered AHB ready returned to the master.

Function
REQ-017 The accept condition SHALL be: valid=1, HTRANS[1]=1 (NONSEQ or SEQ), and HREADYin=1, all sampled at the rising edge.
REQ-018 The FSM SHALL have exactly six states: ST_IDLE, ST_READ, ST_RENABLE, ST_WWAIT, ST_WRITE, ST_WENABLE.
REQ-019 Transitions from ST_IDLE, ST_RENABLE and ST_WENABLE SHALL be:
- accept and HWRITE=1 -> ST_WWAIT
- accept and HWRITE=0 -> ST_READ
- no accept -> ST_IDLE
REQ-020 On accept, the block SHALL capture addr_q<=HADDR and sel_q<=TEMP_SEL.
REQ-021 ST_WWAIT SHALL capture wdata_q<=HWDATA and go unconditionally to ST_WRITE.
REQ-022 Unconditional transitions SHALL be ST_READ -> ST_RENABLE and ST_WRITE -> ST_WENABLE.
REQ-023 Outputs SHALL be registered and decoded from the next state, so each value is valid for the whole cycle spent in that state.
REQ-024 Output values in ST_IDLE: PSEL=000, PENABLE=0, HREADYout=1; PWRITE, PADDR and PWDATA hold their last values.
REQ-025 Output values in ST_READ: PSEL=sel_q, PADDR=addr_q, PWRITE=0, PENABLE=0, HREADYout=0.
REQ-026 Output values in ST_RENABLE: the ST_READ values with PENABLE=1 and HREADYout=1; the master samples read data at the end of this cycle.
REQ-027 Output values in ST_WWAIT: PSEL=000, PENABLE=0, HREADYout=0.
REQ-028 Output values in ST_WRITE: PSEL=sel_q, PADDR=addr_q, PWDATA=wdata_q, PWRITE=1, PENABLE=0, HREADYout=0.
REQ-029 Output values in ST_WENABLE: the ST_WRITE values with PENABLE=1 and HREADYout=1.
REQ-030 Latency from the accept edge to transfer completion SHALL be 2 cycles for a read and 3 cycles for a write.
REQ-031 A back-to-back transfer accepted in ST_RENABLE or ST_WENABLE SHALL move directly to its setup state without passing through ST_IDLE.
REQ-032 On a back-to-back transfer, PSEL MAY stay non-zero while PENABLE SHALL drop to 0 for the setup cycle.
REQ-033 HTRANS=BUSY or IDLE, valid=0, or HREADYin=0 SHALL never start an APB cycle and SHALL leave the captured registers unchanged.
REQ-034 PENABLE=1 SHALL never occur unless the preceding cycle had the same PSEL, PENABLE=0 and an identical PADDR and PWRITE.
REQ-035 Inputs other than those named in REQ-017, REQ-020 and REQ-021 SHALL NOT affect state.

Reset
REQ-036 While HRESETn=0, state SHALL be ST_IDLE and PSEL=000, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, HREADYout=1, with addr_q, sel_q and wdata_q cleared.
REQ-037 Reset asserted mid-transfer SHALL abort the transfer immediately (asynchronously), with no further APB phase issued.
REQ-038 After reset release, the first edge SHALL evaluate the accept condition from ST_IDLE.

Verification
REQ-039 Read: HADDR=0x4000_1004, TEMP_SEL=010, HWRITE=0, NONSEQ, accept -> next cycle PSEL=010, PADDR=0x4000_1004, PENABLE=0, HREADYout=0; following cycle PENABLE=1, HREADYout=1; then ST_IDLE with PSEL=000.
REQ-040 Write: HADDR=0x4000_2008, TEMP_SEL=100, HWRITE=1, then HWDATA=0xDEAD_BEEF -> one cycle with HREADYout=0 and PSEL=000; then PSEL=100, PWRITE=1, PWDATA=0xDEAD_BEEF; then PENABLE=1, HREADYout=1.
REQ-041 Back-to-back: a read accepted during ST_WENABLE -> the next cycle is ST_READ with PENABLE=0 and the new PADDR, with no ST_IDLE cycle between.
REQ-042 Rejected phases: HTRANS=BUSY, valid=0, or HREADYin=0 for 5 cycles -> PSEL stays 000 and HREADYout stays 1.
REQ-043 Reset during ST_WRITE -> outputs are at REQ-036 values within the same cycle, and the next transfer starts cleanly from ST_IDLE.
